// File: rtl/seq_adder_pkg.sv
// seq_adder_pkg: shared FSM state type and index-width helper for seq_chunk_adder
package seq_adder_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/seq_chunk_adder_chunk_add.sv
// chunk_add: combinational CHUNK-bit adder slice, {cout,s} = a+b+cin
// SEQ_CHUNK_ADDER_OVF_EN adds cmsb, the carry into the slice MSB
module chunk_add #(parameter int CHUNK = 4) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] s,
   output logic             cout
`ifdef SEQ_CHUNK_ADDER_OVF_EN
  ,output logic             cmsb
`endif
);
   assign {cout, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
`ifdef SEQ_CHUNK_ADDER_OVF_EN
   assign cmsb = a[CHUNK-1] ^ b[CHUNK-1] ^ s[CHUNK-1];
`endif
endmodule

// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: multi-cycle ripple adder, CHUNK bits per clock, LSB chunk first
// SEQ_CHUNK_ADDER_OVF_EN adds the signed-overflow output ovf
module seq_chunk_adder
   import seq_adder_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             cout
`ifdef SEQ_CHUNK_ADDER_OVF_EN
  ,output logic             ovf
`endif
);
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IW = idx_width(NCHUNK);

   if (WIDTH % CHUNK != 0) begin : g_bad_chunk
      $error("seq_chunk_adder: WIDTH must be a multiple of CHUNK");
   end

   state_t r_state, w_next;
   logic [IW-1:0] r_idx;
   logic [WIDTH-1:0] r_a, r_b, r_part, r_s;
   logic r_c, r_cout, r_done;
   logic [CHUNK-1:0] w_cs;
   logic w_co, w_last, w_accept;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
   logic w_cm, r_cm, r_ovf;
`endif

   // operands shift right each RUN cycle; finished chunks enter partial from the top
   chunk_add #(.CHUNK(CHUNK)) u_add (
      .a   (r_a[CHUNK-1:0]),
      .b   (r_b[CHUNK-1:0]),
      .cin (r_c),
      .s   (w_cs),
      .cout(w_co)
`ifdef SEQ_CHUNK_ADDER_OVF_EN
     ,.cmsb(w_cm)
`endif
   );

   assign ready    = r_state != ST_RUN;
   assign w_accept = ready & start;
   assign w_last   = r_idx == IW'(NCHUNK - 1);
   assign done     = r_done;
   assign s        = r_s;
   assign cout     = r_cout;

   always_comb begin
      w_next = (r_state == ST_RUN) ? (w_last ? ST_DONE : ST_RUN) : (start ? ST_RUN : ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_part  <= '0;
         r_c     <= 1'b0;
         r_s     <= '0;
         r_cout  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_done  <= r_state == ST_DONE;
         if (r_state == ST_DONE) begin
            r_s    <= r_part;
            r_cout <= r_c;
         end
         if (w_accept) begin
            r_a    <= a;
            r_b    <= b;
            r_c    <= cin;
            r_part <= '0;
            r_idx  <= '0;
         end else if (r_state == ST_RUN) begin
            r_a    <= r_a >> CHUNK;
            r_b    <= r_b >> CHUNK;
            r_part <= WIDTH'({w_cs, r_part} >> CHUNK);
            r_c    <= w_co;
            r_idx  <= r_idx + IW'(1);
         end
      end
   end

`ifdef SEQ_CHUNK_ADDER_OVF_EN
   // carry into the MSB is whatever fed the top bit during the last RUN cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cm  <= 1'b0;
         r_ovf <= 1'b0;
      end else begin
         if (r_state == ST_RUN) r_cm <= w_cm;
         if (r_state == ST_DONE) r_ovf <= r_cm ^ r_c;
      end
   end
   assign ovf = r_ovf;
`endif
endmodule

// File: tb/tb_seq_chunk_adder.sv
// tb_seq_chunk_adder: directed and random checks of seq_chunk_adder (16/4 and 8/8) against a transaction model
`timescale 1ns/1ps
module tb_seq_chunk_adder;
   localparam int N = 4, N8 = 1;
   logic clk = 0, reset = 1;
   logic start = 0, cin = 0;
   logic [15:0] a = 0, b = 0;
   logic ready, done, cout;
   logic [15:0] s;
   logic start8 = 0, cin8 = 0;
   logic [7:0] a8 = 0, b8 = 0;
   logic ready8, done8, cout8;
   logic [7:0] s8;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
   logic ovf, ovf8;
`endif
   int n_chk = 0, n_fail = 0;
   bit chk_on = 0;

   always #5 clk = ~clk;

   seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) u_dut (
      .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .cin(cin),
      .ready(ready), .done(done), .s(s), .cout(cout)
`ifdef SEQ_CHUNK_ADDER_OVF_EN
     ,.ovf(ovf)
`endif
   );

   seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) u_dut8 (
      .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8), .cin(cin8),
      .ready(ready8), .done(done8), .s(s8), .cout(cout8)
`ifdef SEQ_CHUNK_ADDER_OVF_EN
     ,.ovf(ovf8)
`endif
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic sovf(input logic [15:0] x, input logic [15:0] y, input logic c, input int w);
      logic [15:0] t;
      t = x + y + 16'(c);
      return (x[w-1] == y[w-1]) && (t[w-1] != x[w-1]);
   endfunction

   // Transaction model: an accepted request keeps the unit busy for N cycles,
   // then one ready cycle, then the result appears with a one-cycle done pulse.
   int m_ph = 0, m_ncomp = 0;
   logic m_done = 0, m_cout = 0, m_ovf = 0, p_ovf = 0, m_rdy;
   logic [15:0] m_s = 0;
   logic [16:0] p_sum = 0;
   assign m_rdy = (m_ph == 0) || (m_ph == N + 1);
   always @(posedge clk) begin
      if (reset) begin
         m_ph <= 0; m_done <= 0; m_s <= 0; m_cout <= 0; m_ovf <= 0;
      end else begin
         m_done <= m_ph == N + 1;
         if (m_ph == N + 1) begin
            {m_cout, m_s} <= p_sum;
            m_ovf <= p_ovf;
            m_ncomp <= m_ncomp + 1;
         end
         if (start && m_rdy) begin
            p_sum <= {1'b0, a} + {1'b0, b} + 17'(cin);
            p_ovf <= sovf(a, b, cin, 16);
            m_ph <= 1;
         end else if (m_ph != 0) m_ph <= (m_ph == N + 1) ? 0 : m_ph + 1;
      end
   end

   int m8_ph = 0;
   logic m8_done = 0, m8_cout = 0, m8_ovf = 0, p8_ovf = 0, m8_rdy;
   logic [7:0] m8_s = 0;
   logic [8:0] p8_sum = 0;
   assign m8_rdy = (m8_ph == 0) || (m8_ph == N8 + 1);
   always @(posedge clk) begin
      if (reset) begin
         m8_ph <= 0; m8_done <= 0; m8_s <= 0; m8_cout <= 0; m8_ovf <= 0;
      end else begin
         m8_done <= m8_ph == N8 + 1;
         if (m8_ph == N8 + 1) begin
            {m8_cout, m8_s} <= p8_sum;
            m8_ovf <= p8_ovf;
         end
         if (start8 && m8_rdy) begin
            p8_sum <= {1'b0, a8} + {1'b0, b8} + 9'(cin8);
            p8_ovf <= sovf({8'h0, a8}, {8'h0, b8}, cin8, 8);
            m8_ph <= 1;
         end else if (m8_ph != 0) m8_ph <= (m8_ph == N8 + 1) ? 0 : m8_ph + 1;
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         chk("ready", 32'(ready), 32'(m_rdy));
         chk("done", 32'(done), 32'(m_done));
         chk("s", 32'(s), 32'(m_s));
         chk("cout", 32'(cout), 32'(m_cout));
         chk("ready8", 32'(ready8), 32'(m8_rdy));
         chk("done8", 32'(done8), 32'(m8_done));
         chk("s8", 32'(s8), 32'(m8_s));
         chk("cout8", 32'(cout8), 32'(m8_cout));
`ifdef SEQ_CHUNK_ADDER_OVF_EN
         chk("ovf", 32'(ovf), 32'(m_ovf));
         chk("ovf8", 32'(ovf8), 32'(m8_ovf));
`endif
      end
   end

   task automatic txn(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                      input logic [15:0] es, input logic ec, input string nm);
      int lat = -1, low = 0;
      a = ta; b = tb; cin = tc; start = 1;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         start = 0; a = 16'hA5A5; b = 16'h5A5A; cin = ~tc;
         if (!ready) low++;
         if (done) begin
            lat = n - 1;
            break;
         end
      end
      chk({nm, "_lat"}, 32'(lat), 32'd5);
      chk({nm, "_rdylow"}, 32'(low), 32'd4);
      chk({nm, "_s"}, 32'(s), 32'(es));
      chk({nm, "_cout"}, 32'(cout), 32'(ec));
   endtask

   logic [32:0] bops [4] = '{{16'h0001, 16'h0002, 1'b0}, {16'h8000, 16'h8000, 1'b1},
                             {16'hABCD, 16'h1234, 1'b0}, {16'hFFFF, 16'hFFFF, 1'b1}};
   logic [16:0] bexp [4] = '{17'h00003, 17'h10001, 17'h0BE01, 17'h1FFFF};

   initial begin
      int cnt, nd, last, base, lat8;
      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_s", 32'(s), 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
      reset = 0;
      chk_on = 1;
      @(negedge clk);

      txn(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, "basic");
      txn(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, "ripple");
`ifdef SEQ_CHUNK_ADDER_OVF_EN
      chk("ovf_ripple", 32'(ovf), 32'd0);
`endif
      txn(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, "cin");
`ifdef SEQ_CHUNK_ADDER_OVF_EN
      txn(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, "ovfpos");
      chk("ovf_pos", 32'(ovf), 32'd1);
`endif

      // start re-pulsed in the middle of RUN must be ignored
      a = 16'h0101; b = 16'h0202; cin = 0; start = 1;
      @(negedge clk); start = 0;
      @(negedge clk); start = 1; a = 16'h1111; b = 16'h1111;
      @(negedge clk); start = 0;
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done) begin
            cnt++;
            chk("ign_s", 32'(s), 32'h0303);
         end
      end
      chk("ign_ndone", 32'(cnt), 32'd1);

      // reset during the second RUN cycle aborts without a done pulse
      a = 16'h1234; b = 16'h1111; start = 1;
      @(negedge clk); start = 0;
      @(negedge clk); reset = 1;
      @(negedge clk);
      chk("abort_ready", 32'(ready), 32'd1);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_s", 32'(s), 32'd0);
      chk("abort_cout", 32'(cout), 32'd0);
      reset = 0;
      cnt = 0;
      repeat (10) begin
         @(negedge clk);
         if (done) cnt++;
      end
      chk("abort_nodone", 32'(cnt), 32'd0);

      // start held high, new operands presented in each ready cycle
      nd = 0; last = 0; start = 1;
      for (int c = 0; c < 32; c++) begin
         if (c % 5 == 0) begin
            if (c / 5 < 4) {a, b, cin} = bops[c/5];
            else start = 0;
         end
         @(negedge clk);
         if (done) begin
            if (nd < 4) chk("b2b_sum", 32'({cout, s}), 32'(bexp[nd]));
            if (nd > 0) chk("b2b_gap", 32'(c - last), 32'd5);
            last = c;
            nd++;
         end
      end
      chk("b2b_count", 32'(nd), 32'd4);

      // single-chunk configuration: one RUN cycle
      lat8 = -1;
      a8 = 8'hFF; b8 = 8'h01; cin8 = 0; start8 = 1;
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk);
         start8 = 0;
         if (done8) begin
            lat8 = n - 1;
            break;
         end
      end
      chk("w8_lat", 32'(lat8), 32'd2);
      chk("w8_s", 32'(s8), 32'h00);
      chk("w8_cout", 32'(cout8), 32'd1);

      // random traffic, starts arriving at any time, until 1000 results complete
      repeat (8) @(negedge clk);
      base = m_ncomp; cnt = 0;
      for (int c = 0; c < 20000 && m_ncomp < base + 1000; c++) begin
         @(negedge clk);
         if (done) cnt++;
         start = $urandom_range(0, 3) != 0;
         a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom_range(0, 1));
         start8 = $urandom_range(0, 2) != 0;
         a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom_range(0, 1));
      end
      chk("rand_ndone", 32'(cnt), 32'd1000);
      start = 0; start8 = 0;
      repeat (10) @(negedge clk);
      chk_on = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
